// File: rtl/frv_asi_ctrl.sv
// frv_asi_ctrl: issue/retire controller between execute-stage dispatch and
// the algorithm-specific instruction unit (AES/SHA2/SHA3). Holds operands
// stable across a multi-cycle operation, captures the result and hands it to
// writeback through a valid/ready handshake. A kill or a watchdog timeout
// aborts the operation and pulses the unit's flush lines for one cycle.
`timescale 1ns/1ps
module frv_asi_ctrl #(
  parameter int XLEN    = 32,
  parameter int OP      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            g_clk,
  input  logic            g_reset,
  // dispatch side
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [OP:0]     s_uop,
  input  logic [XLEN-1:0] s_rs1,
  input  logic [XLEN-1:0] s_rs2,
  input  logic [1:0]      s_shamt,
  input  logic [4:0]      s_rd,
  input  logic            kill,
  // ASI unit side
  output logic            asi_valid,
  output logic [OP:0]     asi_uop,
  output logic [XLEN-1:0] asi_rs1,
  output logic [XLEN-1:0] asi_rs2,
  output logic [1:0]      asi_shamt,
  input  logic            asi_ready,
  input  logic [XLEN-1:0] asi_result,
  output logic            asi_flush_aessub,
  output logic            asi_flush_aesmix,
  output logic [XLEN-1:0] asi_flush_data,
  // writeback side
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic            wb_error,
  output logic [7:0]      busy_cycles
);

  localparam int XL = XLEN - 1;
  // Last BUSY count before the watchdog fires, and the value reported for a
  // timed-out operation.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_VAL  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [OP:0] uop_q, uop_d;
  logic [XL:0] rs1_q, rs1_d;
  logic [XL:0] rs2_q, rs2_d;
  logic [1:0]  shamt_q, shamt_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [XL:0] res_q, res_d;
  logic [7:0]  bcyc_q, bcyc_d;
  logic        accept;

  // Dispatch handshake: free when idle or when the held result retires this
  // cycle; kill always blocks a new issue.
  always_comb begin
    s_ready = ~kill & ((state_q == IDLE) | ((state_q == DONE) & wb_ready));
    accept  = s_valid & s_ready;
  end

  // Next-state and datapath update for all controller registers.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    uop_d   = uop_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    shamt_d = shamt_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;
    bcyc_d  = bcyc_q;

    unique case (state_q)
      IDLE: ;
      BUSY: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (kill) begin
          // Abandoned operation: flush, but do not report an error.
          err_d   = 1'b0;
          state_d = FLUSH;
        end else if (asi_ready) begin
          res_d   = asi_result;
          bcyc_d  = cnt_q;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          res_d   = '0;
          bcyc_d  = TO_VAL;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (kill) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = err_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (kill || wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new instruction (from IDLE, or back-to-back out of DONE) overrides
    // the transition chosen above.
    if (accept) begin
      uop_d   = s_uop;
      rs1_d   = s_rs1;
      rs2_d   = s_rs2;
      shamt_d = s_shamt;
      rd_d    = s_rd;
      cnt_d   = 8'd0;
      err_d   = 1'b0;
      state_d = BUSY;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      // NOTE: operand and result holding registers are reset too, because
      // they drive module outputs directly and must read 0 out of reset.
      state_q <= IDLE;
      uop_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      bcyc_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      uop_q   <= uop_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      shamt_q <= shamt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
      bcyc_q  <= bcyc_d;
    end
  end

  // Output decode from state and holding registers.
  always_comb begin
    asi_valid        = (state_q == BUSY);
    asi_uop          = uop_q;
    asi_rs1          = rs1_q;
    asi_rs2          = rs2_q;
    asi_shamt        = shamt_q;
    asi_flush_aessub = (state_q == FLUSH);
    asi_flush_aesmix = (state_q == FLUSH);
    asi_flush_data   = '0;
    wb_valid         = (state_q == DONE);
    wb_rd            = rd_q;
    wb_result        = res_q;
    wb_error         = err_q;
    busy_cycles      = bcyc_q;
  end

endmodule

// File: tb/tb_frv_asi_ctrl.sv
// Directed testbench for frv_asi_ctrl (TIMEOUT=8). Expected writeback
// transactions go into a scoreboard queue when issued; a monitor pops and
// compares each one as the DUT retires it.
`timescale 1ns/1ps
module tb_frv_asi_ctrl;

  localparam int XLEN = 32;
  localparam int OP   = 4;
  localparam int TO   = 8;

  localparam logic [OP:0] UOP_SHA256_S0 = 5'h10;
  localparam logic [OP:0] UOP_AES_SUB   = 5'h01;

  logic            g_clk = 1'b0;
  logic            g_reset;
  logic            s_valid, s_ready;
  logic [OP:0]     s_uop;
  logic [XLEN-1:0] s_rs1, s_rs2;
  logic [1:0]      s_shamt;
  logic [4:0]      s_rd;
  logic            kill;
  logic            asi_valid;
  logic [OP:0]     asi_uop;
  logic [XLEN-1:0] asi_rs1, asi_rs2;
  logic [1:0]      asi_shamt;
  logic            asi_ready;
  logic [XLEN-1:0] asi_result;
  logic            asi_flush_aessub, asi_flush_aesmix;
  logic [XLEN-1:0] asi_flush_data;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            wb_error;
  logic [7:0]      busy_cycles;

  frv_asi_ctrl #(.XLEN(XLEN), .OP(OP), .TIMEOUT(TO)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_uop(s_uop), .s_rs1(s_rs1),
    .s_rs2(s_rs2), .s_shamt(s_shamt), .s_rd(s_rd), .kill(kill),
    .asi_valid(asi_valid), .asi_uop(asi_uop), .asi_rs1(asi_rs1),
    .asi_rs2(asi_rs2), .asi_shamt(asi_shamt), .asi_ready(asi_ready),
    .asi_result(asi_result), .asi_flush_aessub(asi_flush_aessub),
    .asi_flush_aesmix(asi_flush_aesmix), .asi_flush_data(asi_flush_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_result(wb_result), .wb_error(wb_error), .busy_cycles(busy_cycles)
  );

  always #5 g_clk = ~g_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ASI unit stub: answers once the op has been BUSY for stub_delay cycles.
  logic        stub_en;
  int          stub_delay;
  logic [31:0] stub_result;
  int          bcnt;

  always @(posedge g_clk or posedge g_reset) begin
    if (g_reset) bcnt <= 0;
    else         bcnt <= asi_valid ? bcnt + 1 : 0;
  end

  assign asi_ready  = asi_valid & stub_en & (bcnt == stub_delay);
  assign asi_result = asi_ready ? stub_result : 32'h0;

  // Scoreboard of expected writeback transactions.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        err;
    logic [7:0]  bc;
  } exp_t;
  exp_t sb_q[$];

  int flush_cnt = 0;

  // Monitor: compares each retired result with the head of the scoreboard,
  // and counts flush-pulse cycles.
  always @(negedge g_clk) begin
    if (!g_reset) begin
      if (asi_flush_aessub) flush_cnt++;
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no result at %0t",
                   wb_rd, $time);
        end else if (wb_ready) begin
          exp_t e;
          e = sb_q.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_result", wb_result, e.res);
          check("wb_error", 32'(wb_error), 32'(e.err));
          check("busy_cycles", 32'(busy_cycles), 32'(e.bc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Offer one instruction for one cycle (controller assumed ready).
  task automatic issue(input logic [OP:0] uop, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [1:0] sh,
                       input logic [4:0] rd);
    s_valid = 1'b1; s_uop = uop; s_rs1 = rs1; s_rs2 = rs2; s_shamt = sh; s_rd = rd;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0;
    g_reset = 1'b1; s_valid = 1'b0; s_uop = '0; s_rs1 = '0; s_rs2 = '0;
    s_shamt = '0; s_rd = '0; kill = 1'b0; wb_ready = 1'b0;
    stub_en = 1'b0; stub_delay = 0; stub_result = '0;
    #12;
    // Reset state
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_asi_valid", 32'(asi_valid), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_flush", 32'(asi_flush_aessub | asi_flush_aesmix), 0);
    check("rst_busy_cycles", 32'(busy_cycles), 0);
    #5 g_reset = 1'b0;
    tick();

    // Single-cycle SHA256 op: accept c0, BUSY c1, wb_valid c2
    wb_ready = 1'b1; stub_en = 1'b1; stub_delay = 0; stub_result = 32'hce20b47e;
    sb_q.push_back('{rd: 5'd5, res: 32'hce20b47e, err: 1'b0, bc: 8'd0});
    issue(UOP_SHA256_S0, 32'h6a09e667, 32'h0, 2'd0, 5'd5);
    check("t1_c1_asi_valid", 32'(asi_valid), 1);
    check("t1_c1_wb_valid", 32'(wb_valid), 0);
    check("t1_asi_uop", 32'(asi_uop), 32'(UOP_SHA256_S0));
    check("t1_asi_rs1", asi_rs1, 32'h6a09e667);
    tick();
    check("t1_c2_wb_valid", 32'(wb_valid), 1);
    tick();

    // Multi-cycle AES sub: operands held while inputs change
    stub_delay = 4; stub_result = 32'h63cab704;
    sb_q.push_back('{rd: 5'd12, res: 32'h63cab704, err: 1'b0, bc: 8'd4});
    issue(UOP_AES_SUB, 32'h00112233, 32'h44556677, 2'd1, 5'd12);
    s_rs1 = 32'hffffffff; s_rs2 = 32'hfefefefe; s_shamt = 2'd3;
    n = 0;
    while (asi_valid && n < 20) begin
      check("t2_asi_rs1_held", asi_rs1, 32'h00112233);
      check("t2_asi_rs2_held", asi_rs2, 32'h44556677);
      n++;
      tick();
    end
    check("t2_busy_len", n, 5);
    check("t2_asi_shamt_held", 32'(asi_shamt), 1);
    tick();

    // Writeback backpressure, then back-to-back issue with no bubble
    wb_ready = 1'b0; stub_delay = 0; stub_result = 32'h11110001;
    sb_q.push_back('{rd: 5'd7, res: 32'h11110001, err: 1'b0, bc: 8'd0});
    issue(5'h03, 32'ha5a5a5a5, 32'h0, 2'd0, 5'd7);
    tick();
    s_valid = 1'b1; s_uop = 5'h04; s_rs1 = 32'h0badf00d; s_rs2 = 32'h0;
    s_rd = 5'd9; stub_result = 32'h22220002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_wb_valid_hold", 32'(wb_valid), 1);
      check("t3_wb_result_hold", wb_result, 32'h11110001);
      check("t3_s_ready_low", 32'(s_ready), 0);
      tick();
    end
    sb_q.push_back('{rd: 5'd9, res: 32'h22220002, err: 1'b0, bc: 8'd0});
    wb_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    check("t3_no_bubble", 32'(asi_valid), 1);
    check("t3_b2b_rs1", asi_rs1, 32'h0badf00d);
    tick();
    tick();

    // Kill in the second BUSY cycle: one flush cycle, then IDLE, no result
    stub_en = 1'b0; f0 = flush_cnt;
    issue(5'h01, 32'h01020304, 32'h0, 2'd0, 5'd3);
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("t4_flush_sub", 32'(asi_flush_aessub), 1);
    check("t4_flush_mix", 32'(asi_flush_aesmix), 1);
    check("t4_flush_data", asi_flush_data, 32'h0);
    check("t4_flush_asi_valid", 32'(asi_valid), 0);
    tick();
    #1;
    check("t4_idle_flush", 32'(asi_flush_aessub), 0);
    check("t4_idle_s_ready", 32'(s_ready), 1);
    tick();
    tick();
    check("t4_flush_pulses", flush_cnt - f0, 1);
    check("t4_busy_cycles_hold", 32'(busy_cycles), 0);

    // Timeout: 8 BUSY cycles, one FLUSH, then DONE with error
    sb_q.push_back('{rd: 5'd4, res: 32'h0, err: 1'b1, bc: 8'(TO)});
    issue(5'h02, 32'hcafef00d, 32'h1, 2'd0, 5'd4);
    n = 0;
    while (asi_valid && n < 20) begin
      n++;
      tick();
    end
    check("t5_busy_len", n, TO);
    check("t5_flush", 32'(asi_flush_aessub), 1);
    tick();
    check("t5_done_valid", 32'(wb_valid), 1);
    check("t5_done_error", 32'(wb_error), 1);
    tick();

    // Kill while IDLE drops a simultaneous s_valid
    kill = 1'b1;
    s_valid = 1'b1; s_uop = 5'h05; s_rs1 = 32'h55555555; s_rd = 5'd1;
    #1;
    check("t6_kill_s_ready", 32'(s_ready), 0);
    tick();
    kill = 1'b0; s_valid = 1'b0;
    check("t6_kill_no_issue", 32'(asi_valid), 0);
    tick();

    // Asynchronous reset between edges in mid-BUSY: no flush pulse
    stub_en = 1'b1; stub_delay = 6; f0 = flush_cnt;
    issue(5'h06, 32'h77778888, 32'h9, 2'd2, 5'd6);
    tick();
    #3 g_reset = 1'b1;
    #1;
    check("t7_rst_asi_valid", 32'(asi_valid), 0);
    check("t7_rst_s_ready", 32'(s_ready), 1);
    check("t7_rst_asi_rs1", asi_rs1, 32'h0);
    check("t7_rst_flush", 32'(asi_flush_aessub), 0);
    check("t7_rst_busy_cycles", 32'(busy_cycles), 0);
    #2 g_reset = 1'b0;
    tick();
    check("t7_post_s_ready", 32'(s_ready), 1);
    check("t7_post_asi_valid", 32'(asi_valid), 0);
    check("t7_no_flush", flush_cnt - f0, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
